// File: rtl/defines.v
// Global bus widths shared by the fetch path.
`ifndef DEFINES_V
`define DEFINES_V
`define ADDR_LEN  32
`define INSTR_LEN 32
`endif

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, presents one registered instruction
// to the decoder with a valid/ready handshake, honours redirects and stops
// after delivering the halt instruction.
`include "defines.v"

module inst_fetch #(
  parameter logic [`ADDR_LEN-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [`INSTR_LEN-1:0] HALT_INST = 32'h0000_000C
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [`ADDR_LEN-1:0]  pc_o,
  input  logic [`INSTR_LEN-1:0] inst_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`INSTR_LEN-1:0] out_inst,
  output logic [`ADDR_LEN-1:0]  out_pc,
  input  logic                  redirect_valid,
  input  logic [`ADDR_LEN-1:0]  redirect_target,
  output logic                  halted,
  output logic [31:0]           fetch_cnt
);

  typedef enum logic [1:0] {START, FETCH, HALT} state_t;

  state_t                state_q, state_d;
  logic [`ADDR_LEN-1:0]  pc_q, pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [`INSTR_LEN-1:0] out_inst_q, out_inst_d;
  logic [`ADDR_LEN-1:0]  out_pc_q, out_pc_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;
  logic                  xfer, capture;

  // State and datapath registers; reset clears any pending instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= START;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Next-state: redirect wins over everything except the transfer count;
  // capture refills the output slot when it is empty or draining this cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    xfer        = out_valid_q & out_ready;
    capture     = (state_q == FETCH) & ~redirect_valid & (~out_valid_q | xfer);
    fetch_cnt_d = fetch_cnt_q + {31'd0, xfer};

    if (redirect_valid) begin
      pc_d        = redirect_target & ~32'h3;
      out_valid_d = 1'b0;
      state_d     = FETCH;
    end else if (state_q == START) begin
      state_d = FETCH;
    end else if (capture) begin
      out_inst_d  = inst_i;
      out_pc_d    = pc_q;
      out_valid_d = 1'b1;
      pc_d        = pc_q + 32'd4;
      if (inst_i == HALT_INST) state_d = HALT;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  assign pc_o      = pc_q;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == HALT);
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with fixed expected
// values plus a randomized run checked against a behavioural model.
module tb_inst_fetch;

  localparam logic [31:0] HALT = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_o, inst_i, out_inst, out_pc, redirect_target, fetch_cnt;
  logic        out_valid, out_ready, redirect_valid, halted;

  int checks = 0;
  int errors = 0;

  // Address that returns the halt opcode (unaligned value = none).
  logic [31:0] halt_addr = 32'h1;

  inst_fetch #(.RESET_PC(32'h0), .HALT_INST(HALT)) dut (
    .clk(clk), .rst(rst), .pc_o(pc_o), .inst_i(inst_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == halt_addr) return HALT;
    return {a[15:0] ^ 16'hA5A5, a[31:16]};
  endfunction

  assign inst_i = mem(pc_o);

  // Behavioural model: a "next address" pointer feeding a one-entry slot.
  int          m_phase;   // 0 = just out of reset, 1 = fetching, 2 = stopped
  logic [31:0] m_next, m_inst, m_pc, m_cnt;
  logic        m_full;

  task automatic model_reset();
    m_phase = 0; m_next = 32'h0; m_inst = 0; m_pc = 0; m_cnt = 0; m_full = 0;
  endtask

  task automatic model_step();
    bit taken = m_full && out_ready;
    if (taken) m_cnt = m_cnt + 1;
    if (redirect_valid) begin
      m_next  = {redirect_target[31:2], 2'b00};
      m_full  = 0;
      m_phase = 1;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1 && (!m_full || taken)) begin
      m_inst = mem(m_next);
      m_pc   = m_next;
      m_full = 1;
      if (m_inst == HALT) m_phase = 2;
      m_next = m_next + 32'd4;
    end else if (taken) begin
      m_full = 0;
    end
  endtask

  // One clock: model follows the edge, outputs are then sampled at negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; out_ready = 0; redirect_valid = 0; redirect_target = 0;
    model_reset();
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pc_o, out_valid, out_inst, out_pc, halted, fetch_cnt} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: pc=%h v=%b inst=%h opc=%h h=%b cnt=%0d required all zero",
               pc_o, out_valid, out_inst, out_pc, halted, fetch_cnt);
    end
    tick(); // START -> FETCH edge must not change outputs
    checks++;
    if (out_valid !== 1'b0 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL start_cycle: v=%b pc=%h required v=0 pc=0", out_valid, pc_o);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(k * 4) || out_inst !== mem(32'(k * 4))) begin
        errors++;
        $display("FAIL stream_%0d: v=%b opc=%h inst=%h required opc=%h", k, out_valid, out_pc, out_inst, k * 4);
      end
    end
    tick();
    checks++;
    if (fetch_cnt !== 32'd4) begin
      errors++;
      $display("FAIL stream_cnt: cnt=%0d required 4", fetch_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1;
    tick(); tick(); tick(); // out_pc = 4 now
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_pc !== 32'h4 || out_inst !== mem(32'h4) || pc_o !== 32'h8 || fetch_cnt !== 32'd1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: opc=%h pc=%h cnt=%0d v=%b required opc=4 pc=8 cnt=1 v=1",
                 k, out_pc, pc_o, fetch_cnt, out_valid);
      end
    end
    out_ready = 1;
    tick();
    checks++;
    if (out_pc !== 32'h8 || fetch_cnt !== 32'd2) begin
      errors++;
      $display("FAIL bp_release: opc=%h cnt=%0d required opc=8 cnt=2", out_pc, fetch_cnt);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick(); // out_valid=1 at out_pc 0, ready low
    redirect_valid = 1; redirect_target = 32'h13;
    tick();
    redirect_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || pc_o !== 32'h10) begin
      errors++;
      $display("FAIL redirect_flush: v=%b pc=%h required v=0 pc=10", out_valid, pc_o);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || fetch_cnt !== 32'd0) begin
      errors++;
      $display("FAIL redirect_fetch: v=%b opc=%h cnt=%0d required v=1 opc=10 cnt=0", out_valid, out_pc, fetch_cnt);
    end
  endtask

  task automatic test_halt();
    int n = 0;
    halt_addr = 32'h14;
    do_reset();
    out_ready = 1;
    while (!(out_valid === 1'b1 && out_pc === 32'h14) && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20 || out_inst !== HALT || halted !== 1'b1 || pc_o !== 32'h18) begin
      errors++;
      $display("FAIL halt_deliver: cycles=%0d inst=%h h=%b pc=%h required inst=c h=1 pc=18", n, out_inst, halted, pc_o);
    end
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b1 || pc_o !== 32'h18 || fetch_cnt !== 32'd6) begin
      errors++;
      $display("FAIL halt_idle: v=%b h=%b pc=%h cnt=%0d required v=0 h=1 pc=18 cnt=6", out_valid, halted, pc_o, fetch_cnt);
    end
    redirect_valid = 1; redirect_target = 32'h0;
    tick();
    redirect_valid = 0;
    checks++;
    if (halted !== 1'b0 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL halt_resume: h=%b pc=%h required h=0 pc=0", halted, pc_o);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL halt_refetch: v=%b opc=%h required v=1 opc=0", out_valid, out_pc);
    end
    halt_addr = 32'h1;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1;
    tick();
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: v=%b opc=%h required v=1 opc=fffffffc", out_valid, out_pc);
    end
    tick();
    checks++;
    if (out_pc !== 32'h0 || pc_o !== 32'h4) begin
      errors++;
      $display("FAIL wrap_zero: opc=%h pc=%h required opc=0 pc=4", out_pc, pc_o);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1;
    for (int k = 0; k < 5; k++) tick();
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if ({pc_o, out_valid, out_inst, out_pc, halted, fetch_cnt} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: pc=%h v=%b opc=%h cnt=%0d required all zero", pc_o, out_valid, out_pc, fetch_cnt);
    end
    @(negedge clk);
    rst = 0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_restart: v=%b opc=%h required v=1 opc=0", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    halt_addr = 32'h28;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      out_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 48));
      tick();
      checks++;
      if ({pc_o, out_valid, halted, fetch_cnt} !== {m_next, m_full, m_phase == 2, m_cnt} ||
          (m_full && {out_inst, out_pc} !== {m_inst, m_pc})) begin
        errors++;
        $display("FAIL random_%0d: pc=%h v=%b inst=%h opc=%h h=%b cnt=%0d required pc=%h v=%b inst=%h opc=%h h=%b cnt=%0d",
                 k, pc_o, out_valid, out_inst, out_pc, halted, fetch_cnt,
                 m_next, m_full, m_inst, m_pc, m_phase == 2, m_cnt);
      end
    end
    redirect_valid = 0;
    halt_addr = 32'h1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL include `defines.v` and SHALL size address and instruction buses with `ADDR_LEN and `INSTR_LEN, both 32 bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-003 Parameter HALT_INST, default 32'h0000_000C (syscall), SHALL set the instruction encoding that halts fetch.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 pc_o  out  ADDR_LEN  fetch address driven to the instruction memory addr port.
REQ-008 inst_i  in  INSTR_LEN  instruction returned combinationally by the instruction memory for pc_o.
REQ-009 out_valid  out  1  out_inst/out_pc hold a fetched instruction.
REQ-010 out_ready  in  1  downstream decoder accepts the instruction this cycle.
REQ-011 out_inst  out  INSTR_LEN  fetched instruction.
REQ-012 out_pc  out  ADDR_LEN  address of out_inst.
REQ-013 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-014 redirect_target  in  ADDR_LEN  new fetch address.
REQ-015 halted  out  1  fetch has stopped after delivering HALT_INST.
REQ-016 fetch_cnt  out  32  count of instructions accepted downstream.

Function
REQ-017 State machine: START, FETCH, HALT; START SHALL last exactly one cycle after reset deassertion, then go to FETCH.
REQ-018 pc_o SHALL be the PC register output directly, with no combinational path from any input.
REQ-019 Transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; fetch_cnt SHALL increment by 1 per transfer and wrap from 32'hFFFF_FFFF to 0.
REQ-020 Capture condition (FETCH, no redirect, and out_valid=0 or transfer this cycle): the block SHALL register out_inst<=inst_i, out_pc<=pc_o, out_valid<=1, pc<=pc+4.
REQ-021 When out_valid=1 and out_ready=0, out_inst, out_pc, out_valid and pc SHALL hold unchanged.
REQ-022 When neither capture nor transfer occurs, out_valid SHALL stay unchanged; when a transfer occurs without a capture, out_valid SHALL go to 0.
REQ-023 PC increment SHALL be modulo 2^ADDR_LEN; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-024 Capture of inst_i==HALT_INST SHALL present that instruction normally and move the block to HALT; HALT SHALL perform no further captures and pc SHALL hold.
REQ-025 halted SHALL be 1 exactly while in HALT.
REQ-026 In any state, redirect_valid=1 SHALL load pc<=redirect_target with bits [1:0] forced to 0, set out_valid<=0 and move the state to FETCH; any pending instruction is discarded.
REQ-027 Redirect SHALL take priority over capture, transfer-driven state changes and halt detection in the same cycle; a transfer in that same cycle SHALL still count in fetch_cnt.
REQ-028 redirect_valid during START SHALL load the target and proceed to FETCH on the next cycle.
REQ-029 Fetch latency SHALL be one cycle: an instruction captured at edge N SHALL be visible on out_inst after edge N.

Reset
REQ-030 On rst=1, asynchronously: pc=RESET_PC, state=START, out_valid=0, out_inst=0, out_pc=0, halted=0, fetch_cnt=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending instruction and redirect; no output SHALL change on the first clock edge after deassertion other than the START->FETCH transition.

Verification
REQ-032 Reset release, out_ready=1, memory holds add/sub/and/or at 0x0..0xC -> out_pc 0,4,8,C on consecutive cycles starting the second cycle after START; fetch_cnt=4.
REQ-033 Backpressure: out_ready=0 for 3 cycles while out_pc=4 -> out_inst/out_pc/pc_o stable, fetch_cnt unchanged; release -> out_pc=8 next cycle.
REQ-034 redirect_valid=1, target 32'h0000_0013, with out_valid=1 and out_ready=0 -> next cycle out_valid=0 and pc_o=32'h0000_0010; following cycle out_pc=32'h10.
REQ-035 HALT_INST at 0x14 -> delivered with out_pc=0x14, halted=1, out_valid=0 after transfer, pc_o=0x18 static; a later redirect to 0 -> halted=0, fetching resumes at 0.
REQ-036 Redirect to 32'hFFFF_FFFC -> next captures at 32'hFFFF_FFFC then 32'h0000_0000.
REQ-037 rst asserted mid-stream with out_valid=1 -> outputs reset immediately without waiting for a clock edge; after release, first out_pc=RESET_PC.
